fpu_64_seq_multiplier: RTL

- Multi-cycle IEEE-754 binary64 multiplier: result = A * B. Iterative shift-add mantissa datapath with valid/ready handshakes on both sides.
- Companion to the combinational divider path. Provides the forward operation as a registered, area-lean unit for pipelined FPU clusters.
- Overflow and underflow flag semantics match the existing 64-bit FPU blocks.

---
 rtl/fpu_64_seq_multiplier.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_64_seq_multiplier.sv
// fpu_64_seq_multiplier: multi-cycle IEEE-754 binary64 multiplier, result = A * B.
// The 53x53 mantissa product is built by an iterative shift-add loop.
// The loop retires BITS_PER_CYCLE multiplier bits per clock, LSB first.
// One NORM cycle then normalises, rounds to nearest even and packs the result.
// Special operands (zero, subnormal, inf, NaN) skip the loop and pass through NORM.
// Their results therefore appear one clock after accept.
// Optional macro FPU_SEQ_MUL_EARLY_EXIT_EN: the loop exits as soon as the
// unconsumed multiplier bits are all zero. Results are unchanged; latency varies.
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid / in_ready      operand handshake, A = multiplicand, B = multiplier
//   out_valid / out_ready    result handshake
//   result                   binary64 product
//   overflow / underflow     finite operands gave +-inf / tiny result flushed to +-0
module fpu_64_seq_multiplier #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow
);
    localparam int unsigned MANT_W = 53;
    localparam int unsigned PROD_W = 106;
    localparam int unsigned N_ITER = (MANT_W + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int unsigned MB_W   = N_ITER * BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
    localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t              state, state_next;
    logic [PROD_W-1:0]   acc, ma, addend;
    logic [MB_W-1:0]     mb;
    logic [CNT_W-1:0]    cnt;
    logic signed [12:0]  exp_sum;
    logic                prod_sign, is_special;
    logic                accept, take, mul_last, mul_done;

    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;
    assign mul_last = (cnt == CNT_W'(N_ITER - 1));

`ifdef FPU_SEQ_MUL_EARLY_EXIT_EN
    // Bits still to be consumed after this iteration; all-zero means the sum is final.
    logic [MB_W-1:0] mb_rest;
    assign mb_rest  = mb >> BITS_PER_CYCLE;
    assign mul_done = mul_last || (mb_rest == '0);
`else
    assign mul_done = mul_last;
`endif

    // Operand classification; subnormals count as zero.
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_sign, special_in;
    logic [63:0] special_res;
    always_comb begin
        a_zero     = (A[62:52] == 11'd0);
        b_zero     = (B[62:52] == 11'd0);
        a_inf      = (A[62:52] == 11'h7FF) && (A[51:0] == 52'd0);
        b_inf      = (B[62:52] == 11'h7FF) && (B[51:0] == 52'd0);
        a_nan      = (A[62:52] == 11'h7FF) && (A[51:0] != 52'd0);
        b_nan      = (B[62:52] == 11'h7FF) && (B[51:0] != 52'd0);
        in_sign    = A[63] ^ B[63];
        special_in = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            special_res = QNAN;
        else if (a_inf || b_inf)
            special_res = {in_sign, 11'h7FF, 52'd0};
        else
            special_res = {in_sign, 63'd0};
    end

    // Partial product for the current BITS_PER_CYCLE multiplier bits.
    always_comb begin
        addend = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (mb[i]) addend = addend + (ma << i);
        end
    end

    // Normalise, round to nearest even, and detect range errors.
    logic               hi, guard, sticky, rnd_up, ovf_n, unf_n;
    logic [52:0]        mant;
    logic [53:0]        mant_r;
    logic signed [12:0] exp_f;
    logic [51:0]        frac_f;
    logic [63:0]        norm_res;
    always_comb begin
        hi     = acc[105];
        mant   = hi ? acc[105:53] : acc[104:52];
        guard  = hi ? acc[52] : acc[51];
        sticky = hi ? (|acc[51:0]) : (|acc[50:0]);
        rnd_up = guard && (sticky || mant[0]);
        mant_r = {1'b0, mant} + 54'(rnd_up);
        exp_f  = exp_sum + 13'(hi) + 13'(mant_r[53]);
        frac_f = mant_r[53] ? mant_r[52:1] : mant_r[51:0];
        ovf_n  = (exp_f >= 13'sd2047);
        unf_n  = (exp_f <= 13'sd0);
        if (ovf_n)
            norm_res = {prod_sign, 11'h7FF, 52'd0};
        else if (unf_n)
            norm_res = {prod_sign, 63'd0};
        else
            norm_res = {prod_sign, exp_f[10:0], frac_f};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; specials take the NORM slot without touching the loop.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)   state_next = special_in ? NORM : MUL;
            MUL:  if (mul_done) state_next = NORM;
            NORM:               state_next = DONE;
            DONE: if (take)     state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    // Handshake outputs, datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            acc        <= '0;
            ma         <= '0;
            mb         <= '0;
            cnt        <= '0;
            exp_sum    <= '0;
            prod_sign  <= 1'b0;
            is_special <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            unique case (state)
                IDLE: if (accept) begin
                    prod_sign  <= in_sign;
                    exp_sum    <= 13'(A[62:52]) + 13'(B[62:52]) - 13'd1023;
                    ma         <= PROD_W'({1'b1, A[51:0]});
                    mb         <= MB_W'({1'b1, B[51:0]});
                    acc        <= '0;
                    cnt        <= '0;
                    is_special <= special_in;
                    if (special_in) result <= WIDTH'(special_res);
                end
                MUL: begin
                    acc <= acc + addend;
                    ma  <= ma << BITS_PER_CYCLE;
                    mb  <= mb >> BITS_PER_CYCLE;
                    cnt <= cnt + CNT_W'(1);
                end
                NORM: if (!is_special) begin
                    result    <= WIDTH'(norm_res);
                    overflow  <= ovf_n;
                    underflow <= unf_n;
                end
                DONE: if (take) begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
